// File: rtl/eprisc_bus_uart.sv
// eprisc_bus_uart: memory-mapped 8N1 UART for the epRISC front-side bus.
// Word-addressed registers: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CONTROL.
// 8-entry TX and RX FIFOs, a bit-timed TX shifter and an oversampling-free
// RX sampler that re-checks the start bit at half a bit period.
//
// Bus handshake: an access is valid in any cycle with iEnable high. A write
// (iWrite=1) commits on that rising edge with no wait state. A read (iWrite=0)
// returns data on bData combinationally for as long as the strobe is held;
// a DATA read pops the RX FIFO once, on the first edge after the strobe drops.
module eprisc_bus_uart #(
    parameter int          pFifoDepthLog2 = 3,
    parameter logic [15:0] pResetDivisor  = 16'd433
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [31:0] iAddress,
    inout  wire  [31:0] bData,
    input  logic        iWrite,
    input  logic        iEnable,
    input  logic        iRX,
    output logic        oTX,
    output logic        oInterrupt
);
    localparam int DEPTH = 1 << pFifoDepthLog2;
    localparam int PW    = pFifoDepthLog2 + 1;

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

    logic [15:0]   r_divisor;
    logic [1:0]    r_control;
    logic          r_overrun, r_framing, r_rd_data_d, r_irq;
    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    tx_state_t     r_tx_state, w_tx_next;
    rx_state_t     r_rx_state, w_rx_next;
    logic [15:0]   r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
    logic [2:0]    r_tx_bit, r_rx_bit;
    logic [7:0]    r_tx_shift, r_rx_shift;
    logic          r_tx_out, r_rx_s1, r_rx_s2, r_rx_s3;

    logic          w_wr, w_rd, w_rd_data, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_done;
    logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_idle;
    logic          w_tx_bit_end, w_rx_bit_end, w_rx_half, w_rx_fall, w_overrun_set;
    logic [16:0]   w_rx_half_per;
    logic [7:0]    w_rx_head;
    logic [31:0]   w_status, w_rdata;
    logic          w_unused;

    assign w_wr      = iEnable && iWrite;
    assign w_rd      = iEnable && !iWrite;
    assign w_rd_data = w_rd && (iAddress[1:0] == 2'd0);
    assign w_unused  = ^{iAddress[31:2], bData[31:16]};

    // FIFO flags come from the extra pointer bit: equal = empty, MSB differs = full
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[PW-1] != r_tx_rptr[PW-1]) && (r_tx_wptr[PW-2:0] == r_tx_rptr[PW-2:0]);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[PW-1] != r_rx_rptr[PW-1]) && (r_rx_wptr[PW-2:0] == r_rx_rptr[PW-2:0]);

    assign w_tx_push     = w_wr && (iAddress[1:0] == 2'd0) && (!w_tx_full || w_tx_pop);
    assign w_rx_pop      = r_rd_data_d && !w_rd_data && !w_rx_empty;
    assign w_rx_push     = w_rx_done && (!w_rx_full || w_rx_pop);
    assign w_overrun_set = w_rx_done && w_rx_full && !w_rx_pop;

    assign w_rx_head = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[PW-2:0]];
    assign w_tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);
    assign w_status  = {25'd0, r_framing, r_overrun, w_tx_idle, w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};

    assign w_tx_bit_end  = (r_tx_cnt == r_tx_div);
    assign w_rx_bit_end  = (r_rx_cnt == r_rx_div);
    assign w_rx_half_per = ({1'b0, r_rx_div} + 17'd1) >> 1;
    assign w_rx_half     = (({1'b0, r_rx_cnt} + 17'd1) >= w_rx_half_per);
    assign w_rx_fall     = r_rx_s3 && !r_rx_s2;

    assign oTX        = r_tx_out;
    assign oInterrupt = r_irq;
    assign bData      = w_rd ? w_rdata : 32'hz;

    // Read data mux, selected by word offset
    always_comb begin
        w_rdata = 32'd0;
        case (iAddress[1:0])
            2'd0:    w_rdata = {24'd0, w_rx_head};
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {16'd0, r_divisor};
            default: w_rdata = {30'd0, r_control};
        endcase
    end

    // Control registers, sticky error flags, read-strobe history and interrupt
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_divisor   <= pResetDivisor;
            r_control   <= 2'd0;
            r_overrun   <= 1'b0;
            r_framing   <= 1'b0;
            r_rd_data_d <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_rd_data_d <= w_rd_data;
            r_irq       <= (r_control[0] && !w_rx_empty) || (r_control[1] && w_tx_empty);
            if (w_wr && iAddress[1:0] == 2'd2) r_divisor <= bData[15:0];
            if (w_wr && iAddress[1:0] == 2'd3) r_control <= bData[1:0];
            if (w_wr && iAddress[1:0] == 2'd1) begin
                if (bData[5]) r_overrun <= 1'b0;
                if (bData[6]) r_framing <= 1'b0;
            end
            // a new error in the same cycle as a clear wins
            if (w_overrun_set) r_overrun <= 1'b1;
            if (w_rx_done && !r_rx_s2) r_framing <= 1'b1;
        end
    end

    // FIFO pointers; push and pop in the same cycle are both honoured
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge iClock) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[PW-2:0]] <= bData[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr[PW-2:0]] <= r_rx_shift;
    end

    // TX state register
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    // TX next state; a frame ending with bytes queued chains straight into START
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty) begin w_tx_next = TX_START; w_tx_pop = 1'b1; end
            TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_bit_end) begin
                          if (!w_tx_empty) begin w_tx_next = TX_START; w_tx_pop = 1'b1; end
                          else w_tx_next = TX_IDLE;
                      end
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // TX shifter and bit timer; divisor is captured when the frame starts
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= pResetDivisor;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx_out   <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rptr[PW-2:0]];
            r_tx_div   <= r_divisor;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_out   <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_START: if (w_tx_bit_end) begin r_tx_cnt <= 16'd0; r_tx_out <= r_tx_shift[0]; end
                          else r_tx_cnt <= r_tx_cnt + 16'd1;
                TX_DATA:  if (w_tx_bit_end) begin
                              r_tx_cnt   <= 16'd0;
                              r_tx_shift <= r_tx_shift >> 1;
                              r_tx_bit   <= r_tx_bit + 3'd1;
                              r_tx_out   <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
                          end else r_tx_cnt <= r_tx_cnt + 16'd1;
                TX_STOP:  if (w_tx_bit_end) begin r_tx_cnt <= 16'd0; r_tx_out <= 1'b1; end
                          else r_tx_cnt <= r_tx_cnt + 16'd1;
                default:  begin r_tx_cnt <= 16'd0; r_tx_out <= 1'b1; end
            endcase
        end
    end

    // Two-flop synchronizer on iRX plus one stage for falling-edge detection
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= iRX;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    // RX next state; a start bit that is high again at half period is a glitch
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_done = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_bit_end) begin w_rx_next = RX_IDLE; w_rx_done = 1'b1; end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // RX bit timer and shift register, LSB arrives first
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= pResetDivisor;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            case (r_rx_state)
                RX_IDLE:  begin
                              r_rx_cnt <= 16'd0;
                              r_rx_bit <= 3'd0;
                              if (w_rx_fall) r_rx_div <= r_divisor;
                          end
                RX_START: r_rx_cnt <= w_rx_half ? 16'd0 : r_rx_cnt + 16'd1;
                RX_DATA:  if (w_rx_bit_end) begin
                              r_rx_cnt   <= 16'd0;
                              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                              r_rx_bit   <= r_rx_bit + 3'd1;
                          end else r_rx_cnt <= r_rx_cnt + 16'd1;
                default:  r_rx_cnt <= w_rx_bit_end ? 16'd0 : r_rx_cnt + 16'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_eprisc_bus_uart.sv
// tb_eprisc_bus_uart: directed bench for eprisc_bus_uart with divisor 3
// (4 clocks per bit). A free-running monitor decodes oTX into got_q.
module tb_eprisc_bus_uart;
    logic        clk;
    logic        iReset, iWrite, iEnable, iRX;
    logic [31:0] iAddress;
    wire  [31:0] bData;
    logic        oTX, oInterrupt;
    logic        tb_drive;
    logic [31:0] tb_wdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          start_q[$];

    assign bData = tb_drive ? tb_wdata : 32'hz;

    eprisc_bus_uart dut (
        .iClock     (clk),
        .iReset     (iReset),
        .iAddress   (iAddress),
        .bData      (bData),
        .iWrite     (iWrite),
        .iEnable    (iEnable),
        .iRX        (iRX),
        .oTX        (oTX),
        .oInterrupt (oInterrupt)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: entered and left 1 ns after a rising edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        iEnable = 1'b1; iWrite = 1'b1; iAddress = {30'd0, a};
        tb_wdata = d; tb_drive = 1'b1;
        @(posedge clk); #1;
        iEnable = 1'b0; iWrite = 1'b0; tb_drive = 1'b0;
    endtask

    task automatic bus_read_check(input string tag, input logic [1:0] a, input int ncyc,
                                  input logic [31:0] exp);
        iEnable = 1'b1; iWrite = 1'b0; iAddress = {30'd0, a};
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check(tag, bData, exp);
            @(posedge clk); #1;
        end
        iEnable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            iRX = bits[i];
            repeat (4) @(posedge clk);
            #1;
        end
        iRX = 1'b1;
    endtask

    // oTX monitor: samples near bit centres on falling clock edges
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = 8'd0;
        forever begin
            @(negedge clk);
            if (prev && !oTX && !iReset) begin
                start_q.push_back(cycle);
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = oTX;
                end
                repeat (4) @(negedge clk);
                got_q.push_back(b);
            end
            prev = oTX;
        end
    end

    initial begin
        logic [9:0]  fr;
        logic [31:0] got;
        iReset = 1'b1; iEnable = 1'b0; iWrite = 1'b0; iAddress = 32'd0;
        iRX = 1'b1; tb_drive = 1'b0; tb_wdata = 32'd0;

        // reset state
        repeat (3) @(posedge clk); #1;
        check("rst_otx", oTX, 32'd1);
        check("rst_irq", oInterrupt, 32'd0);
        iReset = 1'b0;
        @(posedge clk); #1;
        bus_read_check("rst_status", 2'd1, 1, 32'h14);
        bus_read_check("rst_divisor", 2'd2, 1, 32'h1B1);
        bus_read_check("rst_control", 2'd3, 1, 32'h0);
        bus_write(2'd2, 32'd3);
        bus_read_check("divisor_rb", 2'd2, 1, 32'd3);

        // single TX frame 0xA5, sampled every clock
        got_q.delete();
        bus_write(2'd0, 32'hA5);
        check("tx_before_edge", oTX, 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            check($sformatf("tx_a5_bit%0d", j / 4), oTX, {31'd0, fr[j / 4]});
        end
        bus_read_check("tx_in_stop", 2'd1, 1, 32'h04);
        bus_read_check("tx_idle_after", 2'd1, 1, 32'h14);
        check("tx_a5_frames", got_q.size(), 32'd1);
        got = (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hDEADBEEF;
        check("tx_a5_byte", got, 32'hA5);

        // TX FIFO: 10 back-to-back writes, first byte goes straight to the
        // shifter, next 8 fill the FIFO, the 10th is dropped
        got_q.delete(); start_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) bus_write(2'd0, i);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(i));
        bus_read_check("txf_full", 2'd1, 1, 32'h08);
        repeat (9 * 40 + 20) @(posedge clk); #1;
        check("txf_frames", got_q.size(), exp_q.size());
        for (int i = 0; i < 9; i++) begin
            got = (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEADBEEF;
            check($sformatf("txf_byte%0d", i), got, {24'd0, exp_q[i]});
        end
        for (int i = 1; i < 9; i++) begin
            got = (i < start_q.size()) ? start_q[i] - start_q[i - 1] : -1;
            check($sformatf("txf_gap%0d", i), got, 32'd40);
        end
        bus_read_check("txf_done", 2'd1, 1, 32'h14);

        // RX: two frames, 3-cycle DATA read pops exactly once
        bus_write(2'd3, 32'd1);
        drive_rx(8'h3C, 1'b1);
        drive_rx(8'h81, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("rx_irq", oInterrupt, 32'd1);
        bus_read_check("rx_status", 2'd1, 1, 32'h15);
        bus_read_check("rx_data_3c", 2'd0, 3, 32'h3C);
        bus_read_check("rx_single_pop", 2'd1, 1, 32'h15);
        bus_read_check("rx_data_81", 2'd0, 1, 32'h81);
        bus_read_check("rx_drained", 2'd1, 1, 32'h14);
        check("rx_irq_clear", oInterrupt, 32'd0);
        bus_read_check("rx_empty_read", 2'd0, 1, 32'h0);
        bus_read_check("rx_empty_nopop", 2'd1, 1, 32'h14);

        // framing error: byte still stored
        drive_rx(8'h5A, 1'b0);
        repeat (3) @(posedge clk); #1;
        bus_read_check("fe_status", 2'd1, 1, 32'h55);
        bus_read_check("fe_data", 2'd0, 1, 32'h5A);

        // overrun: 9 frames into an 8-entry FIFO
        for (int i = 0; i < 9; i++) drive_rx(8'h10 + 8'(i), 1'b1);
        repeat (3) @(posedge clk); #1;
        bus_read_check("ovr_status", 2'd1, 1, 32'h77);
        bus_write(2'd1, 32'h60);
        bus_read_check("flags_cleared", 2'd1, 1, 32'h17);
        for (int i = 0; i < 8; i++)
            bus_read_check($sformatf("ovr_data%0d", i), 2'd0, 1, 32'h10 + i);
        bus_read_check("ovr_drained", 2'd1, 1, 32'h14);

        // glitch: one-clock low pulse enters START then falls back to IDLE
        iRX = 1'b0;
        @(posedge clk); #1;
        iRX = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("glitch_start", dut.r_rx_state, 32'd1);
        repeat (10) @(posedge clk); #1;
        check("glitch_idle", dut.r_rx_state, 32'd0);
        bus_read_check("glitch_status", 2'd1, 1, 32'h14);

        // reset in the middle of a TX frame
        bus_write(2'd3, 32'd2);
        repeat (2) @(posedge clk); #1;
        check("irq_tx_empty", oInterrupt, 32'd1);
        bus_write(2'd0, 32'h00);
        repeat (10) @(posedge clk); #1;
        check("mid_frame_tx", oTX, 32'd0);
        #2;
        iReset = 1'b1;
        #1;
        check("async_rst_tx", oTX, 32'd1);
        check("async_rst_irq", oInterrupt, 32'd0);
        @(posedge clk); #1;
        iReset = 1'b0;
        @(posedge clk); #1;
        bus_read_check("post_rst_status", 2'd1, 1, 32'h14);
        bus_read_check("post_rst_divisor", 2'd2, 1, 32'h1B1);
        bus_read_check("post_rst_control", 2'd3, 1, 32'h0);
        check("post_rst_tx", oTX, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
